mem_bus_arbiter: RTL and testbench

//  Shares one SRAM-style memory port between instruction fetch (IF, read-only) and data access (MEM, read/write).

---
 rtl/mem_bus_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-style port between instruction fetch and data access, one transaction at a time.
// Optional round-robin between the two requesters when ARB_RR_EN is defined; fixed data-first otherwise.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_done,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_done,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                pause_if,
  output logic                pause_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_I_ADDR,
    S_I_DATA,
    S_D_ADDR,
    S_D_DATA
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_drop;
  logic                w_drop_next;
  logic                r_mem_req;
  logic                w_mem_req_next;
  logic                r_mem_we;
  logic                w_mem_we_next;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   w_mem_addr_next;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   w_mem_wdata_next;
  logic [STRB_W-1:0]   r_mem_wstrb;
  logic [STRB_W-1:0]   w_mem_wstrb_next;
  logic                r_inst_done;
  logic                w_inst_done_next;
  logic [DATA_W-1:0]   r_inst_rdata;
  logic [DATA_W-1:0]   w_inst_rdata_next;
  logic                r_data_done;
  logic                w_data_done_next;
  logic [DATA_W-1:0]   r_data_rdata;
  logic [DATA_W-1:0]   w_data_rdata_next;
  logic                w_grant_data;
  logic                w_grant_inst;

`ifdef ARB_RR_EN
  // 0 = data side preferred, 1 = instruction side preferred
  logic r_prio;
  logic w_prio_next;

  assign w_grant_data = data_req & (~inst_req | ~r_prio);
`else
  assign w_grant_data = data_req;
`endif
  assign w_grant_inst = inst_req & ~w_grant_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_drop       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
      r_inst_done  <= 1'b0;
      r_inst_rdata <= '0;
      r_data_done  <= 1'b0;
      r_data_rdata <= '0;
`ifdef ARB_RR_EN
      r_prio       <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_drop       <= w_drop_next;
      r_mem_req    <= w_mem_req_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_mem_wstrb  <= w_mem_wstrb_next;
      r_inst_done  <= w_inst_done_next;
      r_inst_rdata <= w_inst_rdata_next;
      r_data_done  <= w_data_done_next;
      r_data_rdata <= w_data_rdata_next;
`ifdef ARB_RR_EN
      r_prio       <= w_prio_next;
`endif
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_drop_next       = r_drop;
    w_mem_req_next    = r_mem_req;
    w_mem_we_next     = r_mem_we;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_mem_wstrb_next  = r_mem_wstrb;
    w_inst_done_next  = 1'b0;
    w_inst_rdata_next = r_inst_rdata;
    w_data_done_next  = 1'b0;
    w_data_rdata_next = r_data_rdata;
`ifdef ARB_RR_EN
    w_prio_next       = r_prio;
`endif

    case (r_state)
      S_IDLE: begin
        w_drop_next = 1'b0;
        if (w_grant_data) begin
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = data_we;
          w_mem_addr_next  = data_addr;
          w_mem_wdata_next = data_wdata;
          w_mem_wstrb_next = data_wstrb;
          w_state_next     = S_D_ADDR;
`ifdef ARB_RR_EN
          w_prio_next      = 1'b1;
`endif
        end else if (w_grant_inst) begin
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = 1'b0;
          w_mem_addr_next  = inst_addr;
          w_mem_wdata_next = '0;
          w_mem_wstrb_next = '0;
          w_state_next     = S_I_ADDR;
`ifdef ARB_RR_EN
          w_prio_next      = 1'b0;
`endif
        end
      end

      S_I_ADDR: begin
        if (flush) begin
          w_drop_next = 1'b1;
        end
        if (mem_addr_ok) begin
          w_mem_req_next = 1'b0;
          w_state_next   = S_I_DATA;
        end
      end

      S_I_DATA: begin
        if (flush) begin
          w_drop_next = 1'b1;
        end
        // A flush arriving with the response still cancels the done pulse.
        if (mem_data_ok) begin
          if (!(r_drop || flush)) begin
            w_inst_done_next  = 1'b1;
            w_inst_rdata_next = mem_rdata;
          end
          w_drop_next  = 1'b0;
          w_state_next = S_IDLE;
        end
      end

      S_D_ADDR: begin
        if (mem_addr_ok) begin
          w_mem_req_next = 1'b0;
          w_state_next   = S_D_DATA;
        end
      end

      S_D_DATA: begin
        if (mem_data_ok) begin
          w_data_done_next = 1'b1;
          if (!r_mem_we) begin
            w_data_rdata_next = mem_rdata;
          end
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next   = S_IDLE;
        w_mem_req_next = 1'b0;
        w_drop_next    = 1'b0;
      end
    endcase
  end

  assign inst_done  = r_inst_done;
  assign inst_rdata = r_inst_rdata;
  assign data_done  = r_data_done;
  assign data_rdata = r_data_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wstrb  = r_mem_wstrb;

  // Stalls drop in the same cycle the done pulse is seen.
  assign pause_if  = inst_req & ~r_inst_done;
  assign pause_mem = data_req & ~r_data_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the memory side is driven cycle by cycle by hand.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_done;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        pause_if;
  logic        pause_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_done(inst_done), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_done(data_done), .data_rdata(data_rdata),
    .pause_if(pause_if), .pause_mem(pause_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Zero-wait address and data phases; returns in the cycle the done pulse is visible.
  task automatic xact(input string tag, input bit is_data, input logic [31:0] rd);
    check_eq({tag, "_mreq"}, {31'd0, mem_req}, 32'd1);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    check_eq({tag, "_mreq_drop"}, {31'd0, mem_req}, 32'd0);
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    tick;
    mem_data_ok = 1'b0;
    if (is_data) begin
      check_eq({tag, "_ddone"}, {31'd0, data_done}, 32'd1);
      check_eq({tag, "_drdata"}, data_rdata, rd);
      check_eq({tag, "_idone_quiet"}, {31'd0, inst_done}, 32'd0);
    end else begin
      check_eq({tag, "_idone"}, {31'd0, inst_done}, 32'd1);
      check_eq({tag, "_irdata"}, inst_rdata, rd);
      check_eq({tag, "_ddone_quiet"}, {31'd0, data_done}, 32'd0);
    end
  endtask

  task automatic run_pair(input string tag, input bit first_data);
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h40;
    inst_req = 1'b1; inst_addr = 32'h80;
    tick;
    check_eq({tag, "_first_addr"}, mem_addr, first_data ? 32'h40 : 32'h80);
    xact({tag, "_a"}, first_data, 32'h1111_1111);
    if (first_data) begin
      check_eq({tag, "_other_paused"}, {31'd0, pause_if}, 32'd1);
      data_req = 1'b0;
    end else begin
      check_eq({tag, "_other_paused"}, {31'd0, pause_mem}, 32'd1);
      inst_req = 1'b0;
    end
    tick;
    check_eq({tag, "_second_addr"}, mem_addr, first_data ? 32'h80 : 32'h40);
    xact({tag, "_b"}, ~first_data, 32'h2222_2222);
    data_req = 1'b0;
    inst_req = 1'b0;
    tick;
    check_eq({tag, "_end_idle"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    repeat (3) tick;
    check_eq("rst_mreq", {31'd0, mem_req}, 32'd0);
    check_eq("rst_maddr", mem_addr, 32'd0);
    check_eq("rst_idone", {31'd0, inst_done}, 32'd0);
    check_eq("rst_ddone", {31'd0, data_done}, 32'd0);
    rst = 1'b0;
    tick;

    // Single fetch, zero-wait memory.
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    #1;
    check_eq("t1_pause_n", {31'd0, pause_if}, 32'd1);
    tick;
    check_eq("t1_maddr", mem_addr, 32'h1C00_0000);
    check_eq("t1_mwe", {31'd0, mem_we}, 32'd0);
    check_eq("t1_pause_n1", {31'd0, pause_if}, 32'd1);
    xact("t1", 1'b0, 32'h0280_0C0C);
    check_eq("t1_pause_done", {31'd0, pause_if}, 32'd0);
    inst_req = 1'b0;
    tick;
    check_eq("t1_done_pulse", {31'd0, inst_done}, 32'd0);
    check_eq("t1_idle", {31'd0, mem_req}, 32'd0);

    // Write with address phase held for four cycles; requester fields change mid-flight.
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
    tick;
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("t2_mreq_%0d", c), {31'd0, mem_req}, 32'd1);
      check_eq($sformatf("t2_maddr_%0d", c), mem_addr, 32'h100);
      check_eq($sformatf("t2_mwdata_%0d", c), mem_wdata, 32'hDEAD_BEEF);
      check_eq($sformatf("t2_mwstrb_%0d", c), {28'd0, mem_wstrb}, 32'h3);
      check_eq($sformatf("t2_mwe_%0d", c), {31'd0, mem_we}, 32'd1);
      if (c == 0) begin
        data_addr = 32'h200; data_wdata = 32'h0; data_wstrb = 4'hF;
      end
      if (c == 3) mem_addr_ok = 1'b1;
      tick;
    end
    mem_addr_ok = 1'b0;
    check_eq("t2_mreq_drop", {31'd0, mem_req}, 32'd0);
    tick;
    check_eq("t2_no_early_done", {31'd0, data_done}, 32'd0);
    check_eq("t2_pause_mem", {31'd0, pause_mem}, 32'd1);
    mem_data_ok = 1'b1;
    tick;
    mem_data_ok = 1'b0;
    check_eq("t2_ddone", {31'd0, data_done}, 32'd1);
    check_eq("t2_pause_clr", {31'd0, pause_mem}, 32'd0);
    data_req = 1'b0; data_we = 1'b0;
    tick;
    check_eq("t2_ddone_pulse", {31'd0, data_done}, 32'd0);

    // Simultaneous requests from a known priority state.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    run_pair("t3p1", 1'b1);
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h44;
    tick;
    xact("t3lone", 1'b1, 32'h3333_3333);
    data_req = 1'b0;
    tick;
`ifdef ARB_RR_EN
    run_pair("t3p2", 1'b0);
`else
    run_pair("t3p2", 1'b1);
`endif

    // Flush during the data phase of a fetch.
    inst_req = 1'b1; inst_addr = 32'h500;
    tick;
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    flush = 1'b1; inst_req = 1'b0;
    tick;
    flush = 1'b0;
    check_eq("t4_no_done_a", {31'd0, inst_done}, 32'd0);
    tick;
    mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick;
    mem_data_ok = 1'b0;
    check_eq("t4_no_done_b", {31'd0, inst_done}, 32'd0);
    check_eq("t4_pause_if", {31'd0, pause_if}, 32'd0);
    tick;
    check_eq("t4_no_done_c", {31'd0, inst_done}, 32'd0);
    inst_req = 1'b1; inst_addr = 32'h504;
    tick;
    check_eq("t4_new_addr", mem_addr, 32'h504);
    xact("t4new", 1'b0, 32'h600D_600D);
    inst_req = 1'b0;
    tick;

    // Flush coinciding with the response.
    inst_req = 1'b1; inst_addr = 32'h508;
    tick;
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; flush = 1'b1; inst_req = 1'b0;
    tick;
    mem_data_ok = 1'b0; flush = 1'b0;
    check_eq("t4b_no_done", {31'd0, inst_done}, 32'd0);
    check_eq("t4b_irdata_kept", inst_rdata, 32'h600D_600D);
    tick;
    check_eq("t4b_idle", {31'd0, mem_req}, 32'd0);

    // Reset during the data address phase, then a stray response.
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h300; data_wdata = 32'h1234_5678; data_wstrb = 4'hF;
    tick;
    check_eq("t5_mreq", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; data_req = 1'b0;
    tick;
    rst = 1'b0;
    check_eq("t5_mreq_rst", {31'd0, mem_req}, 32'd0);
    check_eq("t5_maddr_rst", mem_addr, 32'd0);
    check_eq("t5_ddone_rst", {31'd0, data_done}, 32'd0);
    mem_data_ok = 1'b1;
    tick;
    mem_data_ok = 1'b0;
    check_eq("t5_stray_ddone", {31'd0, data_done}, 32'd0);
    check_eq("t5_stray_idone", {31'd0, inst_done}, 32'd0);
    tick;
    check_eq("t5_stray_ddone2", {31'd0, data_done}, 32'd0);
    check_eq("t5_stray_mreq", {31'd0, mem_req}, 32'd0);

    // Back-to-back fetches with inst_req held: one idle cycle between each.
    inst_req = 1'b1; inst_addr = 32'h1000;
    tick;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("t6_maddr_%0d", k), mem_addr, 32'h1000 + 32'(4 * k));
      xact($sformatf("t6_%0d", k), 1'b0, 32'hA000_0000 + 32'(k));
      check_eq($sformatf("t6_idle_%0d", k), {31'd0, mem_req}, 32'd0);
      if (k < 2) inst_addr = 32'h1000 + 32'(4 * (k + 1));
      else       inst_req  = 1'b0;
      tick;
    end
    check_eq("t6_end_mreq", {31'd0, mem_req}, 32'd0);
    check_eq("t6_end_idone", {31'd0, inst_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
